// File: rtl/fp_butterfly_stage.sv
// Radix-2 butterfly stage on complex fixed-point operands: c0 = a + b*w, c1 = a - b*w.
// The product comes from an external complex multiplier over a request/response handshake.
module fp_butterfly_stage #(
  parameter int n = 32,
  parameter int d = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  input  logic [n-1:0] wr,
  input  logic [n-1:0] wc,
  output logic         mul_req_val,
  input  logic         mul_req_rdy,
  output logic [n-1:0] mul_ar,
  output logic [n-1:0] mul_ac,
  output logic [n-1:0] mul_br,
  output logic [n-1:0] mul_bc,
  input  logic         mul_resp_val,
  output logic         mul_resp_rdy,
  input  logic [n-1:0] mul_cr,
  input  logic [n-1:0] mul_cc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c0r,
  output logic [n-1:0] c0c,
  output logic [n-1:0] c1r,
  output logic [n-1:0] c1c,
  output logic [1:0]   fsm_state
);

  // Handshakes: a transfer happens on a rising edge where both val and rdy are high;
  // a producer holds val and its data stable until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [n-1:0] one_fx = {{(n-1){1'b0}}, 1'b1} << d;

  state_t       state;
  logic [n-1:0] a_r, a_c, b_r, b_c, w_r, w_c;

  assign mul_ar    = b_r;
  assign mul_ac    = b_c;
  assign mul_br    = w_r;
  assign mul_bc    = w_c;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      recv_rdy     <= 1'b1;
      mul_req_val  <= 1'b0;
      mul_resp_rdy <= 1'b0;
      send_val     <= 1'b0;
      a_r <= '0; a_c <= '0;
      b_r <= '0; b_c <= '0;
      w_r <= '0; w_c <= '0;
      c0r <= '0; c0c <= '0;
      c1r <= '0; c1c <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (recv_val) begin
            a_r <= ar; a_c <= ac;
            b_r <= br; b_c <= bc;
            w_r <= wr; w_c <= wc;
            recv_rdy <= 1'b0;
            // Twiddle of exactly 1.0 needs no multiply: p = b.
            if (wr == one_fx && wc == '0) begin
              c0r      <= ar + br;
              c0c      <= ac + bc;
              c1r      <= ar - br;
              c1c      <= ac - bc;
              send_val <= 1'b1;
              state    <= DONE;
            end else begin
              mul_req_val <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (mul_req_rdy) begin
            mul_req_val  <= 1'b0;
            mul_resp_rdy <= 1'b1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (mul_resp_val) begin
            c0r          <= a_r + mul_cr;
            c0c          <= a_c + mul_cc;
            c1r          <= a_r - mul_cr;
            c1c          <= a_c - mul_cc;
            mul_resp_rdy <= 1'b0;
            send_val     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (send_rdy) begin
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          recv_rdy     <= 1'b1;
          mul_req_val  <= 1'b0;
          mul_resp_rdy <= 1'b0;
          send_val     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_butterfly_stage.sv
// Self-checking bench for fp_butterfly_stage with a mock complex multiplier and a result scoreboard.
`timescale 1ns/1ps
module tb_fp_butterfly_stage;

  localparam int N = 32;
  localparam logic [N-1:0] ONE = 32'h0001_0000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         recv_val = 1'b0;
  logic         recv_rdy;
  logic [N-1:0] ar = '0, ac = '0, br = '0, bc = '0, wr = '0, wc = '0;
  logic         mul_req_val;
  logic         mul_req_rdy;
  logic [N-1:0] mul_ar, mul_ac, mul_br, mul_bc;
  logic         mul_resp_val;
  logic         mul_resp_rdy;
  logic [N-1:0] mul_cr, mul_cc;
  logic         send_val;
  logic         send_rdy = 1'b0;
  logic [N-1:0] c0r, c0c, c1r, c1c;
  logic [1:0]   fsm_state;

  fp_butterfly_stage #(.n(N), .d(16)) dut (
    .clk(clk), .reset(reset),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy),
    .mul_ar(mul_ar), .mul_ac(mul_ac), .mul_br(mul_br), .mul_bc(mul_bc),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy),
    .mul_cr(mul_cr), .mul_cc(mul_cc),
    .send_val(send_val), .send_rdy(send_rdy),
    .c0r(c0r), .c0c(c0c), .c1r(c1r), .c1c(c1c),
    .fsm_state(fsm_state)
  );

  // ---------------- clock / reset / counters ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int req_xfers = 0, resp_xfers = 0, send_xfers = 0;
  logic [4*N-1:0] exp_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (mul_req_val && mul_req_rdy) req_xfers <= req_xfers + 1;
      if (mul_resp_val && mul_resp_rdy) resp_xfers <= resp_xfers + 1;
      if (send_val && send_rdy) send_xfers <= send_xfers + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- golden model ----------------
  function automatic logic [2*N-1:0] cmul(input logic [N-1:0] b_r, b_c, w_r, w_c);
    logic signed [63:0] sb_r, sb_c, sw_r, sw_c, pr, pc;
    sb_r = $signed(b_r); sb_c = $signed(b_c);
    sw_r = $signed(w_r); sw_c = $signed(w_c);
    pr = (sb_r * sw_r - sb_c * sw_c) >>> 16;
    pc = (sb_r * sw_c + sb_c * sw_r) >>> 16;
    return {pr[31:0], pc[31:0]};
  endfunction

  // ---------------- mock multiplier ----------------
  logic         mock_on = 1'b1, mock_rand = 1'b0, mock_fixed = 1'b0;
  int           mock_req_dly = 0, mock_resp_dly = 0;
  logic [N-1:0] mock_pr = '0, mock_pc = '0;
  logic         mk_req_rdy = 1'b0, mk_resp_val = 1'b0;
  logic [N-1:0] mk_cr = '0, mk_cc = '0;
  logic         man_req_rdy = 1'b0, man_resp_val = 1'b0;
  logic [N-1:0] man_cr = '0, man_cc = '0;

  assign mul_req_rdy  = mock_on ? mk_req_rdy  : man_req_rdy;
  assign mul_resp_val = mock_on ? mk_resp_val : man_resp_val;
  assign mul_cr       = mock_on ? mk_cr       : man_cr;
  assign mul_cc       = mock_on ? mk_cc       : man_cc;

  task automatic mock_serve();
    logic [2*N-1:0] pp;
    int rd, sd, k;
    rd = mock_rand ? int'($urandom_range(0, 3)) : mock_req_dly;
    sd = mock_rand ? int'($urandom_range(0, 3)) : mock_resp_dly;
    pp = mock_fixed ? {mock_pr, mock_pc} : cmul(mul_ar, mul_ac, mul_br, mul_bc);
    repeat (rd) @(negedge clk);
    mk_req_rdy = 1'b1;
    @(negedge clk);
    mk_req_rdy = 1'b0;
    repeat (sd) @(negedge clk);
    mk_resp_val = 1'b1;
    mk_cr = pp[2*N-1:N];
    mk_cc = pp[N-1:0];
    k = 0;
    while (!mul_resp_rdy && k < 1000) begin @(negedge clk); k++; end
    @(negedge clk);
    mk_resp_val = 1'b0;
    mk_cr = $urandom;
    mk_cc = $urandom;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mock_on && mul_req_val) mock_serve();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [N-1:0] a_r, a_c, b_r, b_c, w_r, w_c);
    logic [N-1:0] p_r, p_c;
    logic [2*N-1:0] pp;
    int k;
    k = 0;
    while (!recv_rdy && k < 200) begin @(negedge clk); k++; end
    if (!recv_rdy) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout: recv_rdy=%b, want 1", recv_rdy);
      return;
    end
    ar = a_r; ac = a_c; br = b_r; bc = b_c; wr = w_r; wc = w_c;
    recv_val = 1'b1;
    if (w_r == ONE && w_c == '0) pp = {b_r, b_c};
    else if (mock_fixed) pp = {mock_pr, mock_pc};
    else pp = cmul(b_r, b_c, w_r, w_c);
    p_r = pp[2*N-1:N];
    p_c = pp[N-1:0];
    exp_q.push_back({a_r + p_r, a_c + p_c, a_r - p_r, a_c - p_c});
    @(negedge clk);
    acc_cyc = cyc;
    recv_val = 1'b0;
    ar = $urandom; ac = $urandom; br = $urandom; bc = $urandom; wr = $urandom; wc = $urandom;
  endtask

  // Waits for send_val, holds send_rdy low for 'hold' cycles, then takes the result.
  task automatic wait_result(input int hold, output logic [4*N-1:0] got, output int lat);
    int k;
    k = 0;
    got = '0;
    lat = -1;
    while (!send_val && k < 200) begin @(negedge clk); k++; end
    if (!send_val) begin
      tests_run++; tests_failed++;
      $display("FAIL result_timeout: send_val=%b, want 1", send_val);
      return;
    end
    lat = cyc - acc_cyc + 1;
    repeat (hold) @(negedge clk);
    got = {c0r, c0c, c1r, c1c};
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if ({recv_rdy, send_val, mul_req_val, mul_resp_rdy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_handshake: got %b, want 1000", {recv_rdy, send_val, mul_req_val, mul_resp_rdy});
    end
    tests_run++;
    if ({c0r, c0c, c1r, c1c} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, want 0", {c0r, c0c, c1r, c1c});
    end
    tests_run++;
    if ({mul_ar, mul_ac, mul_br, mul_bc} !== '0 || fsm_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_operands: got %h state %0d, want 0 state 0", {mul_ar, mul_ac, mul_br, mul_bc}, fsm_state);
    end
  endtask

  task automatic test_basic();
    logic [4*N-1:0] got, exp;
    int lat, r0;
    r0 = req_xfers;
    mock_rand = 1'b0; mock_req_dly = 0; mock_resp_dly = 0;
    drive_op(32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000);
    wait_result(0, got, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp || exp !== {32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0}) begin
      tests_failed++;
      $display("FAIL basic_result: got %h, want %h", got, {32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h0});
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d, want 3", lat);
    end
    tests_run++;
    if (req_xfers - r0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_req_count: got %0d, want 1", req_xfers - r0);
    end
  endtask

  task automatic test_bypass();
    logic [4*N-1:0] got, exp;
    int lat, r0;
    r0 = req_xfers;
    drive_op(32'h0, 32'h0, 32'h0000_8000, 32'h0000_8000, ONE, 32'h0);
    wait_result(0, got, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp || exp !== {32'h0000_8000, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_8000}) begin
      tests_failed++;
      $display("FAIL bypass_result: got %h, want %h", got, {32'h0000_8000, 32'h0000_8000, 32'hFFFF_8000, 32'hFFFF_8000});
    end
    tests_run++;
    if (lat !== 1) begin
      tests_failed++;
      $display("FAIL bypass_latency: got %0d, want 1", lat);
    end
    tests_run++;
    if (req_xfers !== r0) begin
      tests_failed++;
      $display("FAIL bypass_no_request: got %0d requests, want 0", req_xfers - r0);
    end
  endtask

  task automatic test_wrap();
    logic [4*N-1:0] got, exp;
    int lat;
    mock_fixed = 1'b1; mock_pr = 32'h0000_0001; mock_pc = 32'h0;
    drive_op(32'h7FFF_FFFF, 32'h0, 32'h0000_0003, 32'h0, 32'h0, 32'h0001_0000);
    wait_result(0, got, lat);
    exp = exp_q.pop_front();
    mock_fixed = 1'b0;
    tests_run++;
    if (got !== exp || exp !== {32'h8000_0000, 32'h0, 32'h7FFF_FFFE, 32'h0}) begin
      tests_failed++;
      $display("FAIL wrap_result: got %h, want %h", got, {32'h8000_0000, 32'h0, 32'h7FFF_FFFE, 32'h0});
    end
  endtask

  task automatic test_stall();
    logic [4*N-1:0] got, exp;
    logic [N-1:0] b_r, b_c, w_r, w_c;
    int k, r0, s0, p0, bad;
    r0 = req_xfers; p0 = resp_xfers; s0 = send_xfers; bad = 0;
    mock_req_dly = 4; mock_resp_dly = 6;
    b_r = 32'h0001_8000; b_c = 32'hFFFF_0000; w_r = 32'h0000_C000; w_c = 32'h0000_4000;
    drive_op(32'h1234_0000, 32'hFEDC_0000, b_r, b_c, w_r, w_c);
    exp = exp_q[0];
    k = 0;
    while (!send_val && k < 200) begin
      if ((fsm_state == 2'd1 || fsm_state == 2'd2) && {mul_ar, mul_ac, mul_br, mul_bc} !== {b_r, b_c, w_r, w_c}) bad++;
      @(negedge clk); k++;
    end
    for (int i = 0; i < 5; i++) begin
      if (!send_val || {c0r, c0c, c1r, c1c} !== exp) bad++;
      @(negedge clk);
    end
    wait_result(0, got, k);
    exp = exp_q.pop_front();
    mock_req_dly = 0; mock_resp_dly = 0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL stall_stability: got %0d unstable cycles, want 0", bad);
    end
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL stall_result: got %h, want %h", got, exp);
    end
    tests_run++;
    if ({req_xfers - r0, resp_xfers - p0, send_xfers - s0} !== {32'd1, 32'd1, 32'd1}) begin
      tests_failed++;
      $display("FAIL stall_transfers: got req %0d resp %0d send %0d, want 1 1 1", req_xfers - r0, resp_xfers - p0, send_xfers - s0);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [4*N-1:0] got, exp;
    int lat, s0;
    s0 = send_xfers;
    mock_on = 1'b0;
    drive_op(32'h0005_0000, 32'h0006_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000);
    man_resp_val = 1'b1; man_cr = 32'hDEAD_BEEF; man_cc = 32'hCAFE_F00D;
    @(negedge clk);
    tests_run++;
    if (fsm_state !== 2'd1 || mul_resp_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL resp_outside_wait: got state %0d rdy %b, want state 1 rdy 0", fsm_state, mul_resp_rdy);
    end
    man_resp_val = 1'b0; man_req_rdy = 1'b1;
    @(negedge clk);
    man_req_rdy = 1'b0;
    tests_run++;
    if (fsm_state !== 2'd2 || mul_resp_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL enter_wait: got state %0d rdy %b, want state 2 rdy 1", fsm_state, mul_resp_rdy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    man_resp_val = 1'b1;
    @(negedge clk);
    man_resp_val = 1'b0;
    tests_run++;
    if ({fsm_state, recv_rdy, send_val, mul_req_val, mul_resp_rdy} !== 6'b00_1000) begin
      tests_failed++;
      $display("FAIL reset_in_wait_state: got %b, want 001000", {fsm_state, recv_rdy, send_val, mul_req_val, mul_resp_rdy});
    end
    tests_run++;
    if ({c0r, c0c, c1r, c1c} !== '0 || send_xfers !== s0) begin
      tests_failed++;
      $display("FAIL reset_in_wait_outputs: got %h sends %0d, want 0 sends 0", {c0r, c0c, c1r, c1c}, send_xfers - s0);
    end
    exp_q.delete();
    mock_on = 1'b1;
    drive_op(32'h0003_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000);
    wait_result(1, got, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL after_reset_result: got %h, want %h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int errs, cnt;
    errs = 0; cnt = 0;
    mock_rand = 1'b1;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          logic [N-1:0] w_r, w_c;
          if ($urandom_range(0, 7) == 0) begin w_r = ONE; w_c = '0; end
          else begin w_r = $urandom; w_c = $urandom; end
          drive_op($urandom, $urandom, $urandom, $urandom, w_r, w_c);
        end
      end
      begin
        for (int j = 0; j < 200; j++) begin
          logic [4*N-1:0] got, exp;
          int lat;
          wait_result(int'($urandom_range(0, 3)), got, lat);
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          cnt++;
          tests_run++;
          if (got !== exp) begin
            tests_failed++; errs++;
            if (errs < 10) $display("FAIL b2b_result[%0d]: got %h, want %h", j, got, exp);
          end
        end
      end
    join
    mock_rand = 1'b0;
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL b2b_leftover: got %0d pending, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_wrap();
    test_stall();
    test_reset_in_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fp_butterfly_stage.md
FP_BUTTERFLY_STAGE -- requirements
Module: fp_butterfly_stage

Interface
REQ-001: Parameter n, default 32, SHALL set the bit width of every data port (two's-complement fixed point).
REQ-002: Parameter d, default 16, SHALL set the number of fraction bits; it defines the 1.0 constant (1 << d) used for bypass detection.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004: reset  input  1  SHALL be synchronous and active-high.
REQ-005: recv_val input 1 / recv_rdy output 1  SHALL form the upstream operand handshake.
REQ-006: ar, ac, br, bc, wr, wc  input  n each  SHALL carry the complex operands a, b and twiddle w (real, imaginary).
REQ-007: mul_req_val output 1 / mul_req_rdy input 1  SHALL form the request handshake to the external complex multiplier.
REQ-008: mul_ar, mul_ac, mul_br, mul_bc  output  n each  SHALL carry the multiplier operands b and w.
REQ-009: mul_resp_val input 1 / mul_resp_rdy output 1  SHALL form the multiplier result handshake.
REQ-010: mul_cr, mul_cc  input  n each  SHALL carry the product p = b*w.
REQ-011: send_val output 1 / send_rdy input 1  SHALL form the downstream result handshake.
REQ-012: c0r, c0c, c1r, c1c  output  n each  SHALL carry c0 = a + p and c1 = a - p.

Function
REQ-013: The FSM SHALL have exactly four states: IDLE, REQ, WAIT, DONE.
REQ-014: IDLE: recv_rdy=1, all other valid/ready outputs 0; on recv_val, register a, b, w.
REQ-015: From IDLE on accept, the next state SHALL be REQ if w != (1<<d, 0), else DONE with p = b (bypass, no multiplier transaction).
REQ-016: REQ: mul_req_val=1, mul_* operands driven from registered b, w and held stable; on mul_req_rdy -> WAIT; otherwise stay in REQ.
REQ-017: WAIT: mul_resp_rdy=1; on mul_resp_val, capture mul_cr/mul_cc as p, register c0/c1 -> DONE; otherwise stay in WAIT.
REQ-018: mul_resp_val outside WAIT SHALL be ignored; mul_resp_rdy SHALL be 0 outside WAIT.
REQ-019: DONE: send_val=1, outputs held stable; on send_rdy -> IDLE; otherwise stay in DONE.
REQ-020: recv_rdy SHALL be 0 in REQ, WAIT and DONE; a new operand is never accepted in the same cycle a result is sent.
REQ-021: c0 = a + p and c1 = a - p SHALL be computed per component, n-bit, modulo 2^n (wrap, no saturation, no rescale).
REQ-022: Minimum latency SHALL be 3 cycles from accept edge to send_val (multiplier ready and responding immediately); bypass latency SHALL be 1 cycle.
REQ-023: Output registers SHALL update only on the WAIT->DONE or IDLE->DONE transition.

Reset
REQ-024: On reset, the state SHALL become IDLE and c0r, c0c, c1r, c1c and all operand registers SHALL clear to 0.
REQ-025: Reset asserted in any state, including mid-REQ or mid-WAIT, SHALL abandon the operation; send_val, mul_req_val and mul_resp_rdy SHALL be 0 and recv_rdy SHALL be 1 in the first cycle after reset.

Verification
REQ-026: a=(0x00020000,0x00010000), b=(0x00010000,0), w=(0,0x00010000); mock multiplier returns p=(0,0x00010000) immediately -> c0=(0x00020000,0x00020000), c1=(0x00020000,0); send_val 3 cycles after accept.
REQ-027: w=(0x00010000,0), b=(0x00008000,0x00008000), a=0 -> mul_req_val never asserted; c0=(0x00008000,0x00008000), c1=(0xFFFF8000,0xFFFF8000) one cycle after accept.
REQ-028: ar=0x7FFFFFFF; mock returns p=(0x00000001,0) -> c0r=0x80000000, c1r=0x7FFFFFFE (wrap).
REQ-029: mul_req_rdy held low 4 cycles, then response delayed 6 cycles; send_rdy held low 5 cycles -> operands and outputs stable throughout; exactly one request and one result transfer.
REQ-030: Reset pulsed in WAIT, then mock asserts mul_resp_val -> response ignored, state IDLE, outputs 0; the next operand set completes correctly.
REQ-031: 200 back-to-back random operand sets with random multiplier delays and send_rdy back-pressure -> every result matches the golden model bit-exactly, in order.
